sync_multi_ldq: RTL and testbench

Single-clock, multi-channel load queue for the SpMV datapath. NUM_CH requesters share one DDR read port. Each request carries a per-channel stream ID. The block turns each request into a line address from a base table plus a per-ID auto-incrementing offset, issues it to DDR, and holds the returned lines in a pre-allocated in-order buffer. It then serialises each line into LDQ-width beats on the owning channel. It is the successor to the async per-channel load queues: same clock domain as DDR, shared buffer, round-robin arbitration, streaming offsets and width conversion.

---
 rtl/sync_ldq_pkg.sv | 23 ++
 rtl/ldq_rr_arbiter.sv | 38 +++
 rtl/sync_multi_ldq.sv | 127 ++++++++++++
 tb/tb_sync_multi_ldq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_ldq_pkg.sv
// sync_ldq_pkg: default configuration, derived widths and the line-address helper for sync_multi_ldq
// Contents: DEF_* default parameters, RATIO/ID_WIDTH/TAG_WIDTH for the default build,
// w_of() (index width that never collapses to 0), line_addr() (line index to byte address).
package sync_ldq_pkg;
    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_IDS_NUM        = 8;
    localparam int DEF_DDR_DATA_WIDTH = 512;
    localparam int DEF_LDQ_DATA_WIDTH = 128;

    function automatic int w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RATIO     = DEF_DDR_DATA_WIDTH / DEF_LDQ_DATA_WIDTH;
    localparam int ID_WIDTH  = w_of(DEF_IDS_NUM);
    localparam int TAG_WIDTH = w_of(DEF_NUM_CH);

    // The sum is formed at full width before shifting, so only the final
    // byte address is truncated by the caller.
    function automatic logic [63:0] line_addr(input logic [63:0] base, input logic [63:0] offset, input int shift);
        return (base + offset) << shift;
    endfunction
endpackage

// File: rtl/ldq_rr_arbiter.sv
// ldq_rr_arbiter: N-way round-robin arbiter with a rotating priority pointer
// Ports: clk, rst (sync, active-high); req[N] requests; grant[N] one-hot or zero;
// grant_idx encoded winner; any high when a grant is issued.
module ldq_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any
);
    logic [W-1:0] ptr;
    logic [W-1:0] idx;

    // ptr holds the highest-priority channel: the one after the last winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (any) ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
endmodule

// File: rtl/sync_multi_ldq.sv
// sync_multi_ldq: multi-channel load queue sharing one DDR read port with an in-order line buffer
// Ports: sys_clk/sys_rst (sync, active-high); req_valid/req_ready/req_id per-channel requests;
// addr_base per-(channel,id) base line table; offset_clr zeroes all offsets;
// data_valid/data/data_ready per-channel LDQ-width beats; ddr_addr_* read address channel;
// ddr_data_valid/ddr_data returned lines; busy activity flag; err_unexpected sticky orphan-data flag.
module sync_multi_ldq
    import sync_ldq_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int IDS_NUM         = DEF_IDS_NUM,
    parameter int DDR_DATA_WIDTH  = DEF_DDR_DATA_WIDTH,
    parameter int LDQ_DATA_WIDTH  = DEF_LDQ_DATA_WIDTH,
    parameter int ADDR_WIDTH      = 32,
    parameter int BASE_ADDR_WIDTH = 20,
    parameter int OFFSET_WIDTH    = 12,
    parameter int LINE_SHIFT      = 6,
    parameter int QPTR_WIDTH      = 4
) (
    input  logic                                        sys_clk,
    input  logic                                        sys_rst,
    input  logic [NUM_CH-1:0]                           req_valid,
    output logic [NUM_CH-1:0]                           req_ready,
    input  logic [NUM_CH*w_of(IDS_NUM)-1:0]             req_id,
    input  logic [NUM_CH*IDS_NUM*BASE_ADDR_WIDTH-1:0]   addr_base,
    input  logic                                        offset_clr,
    output logic [NUM_CH-1:0]                           data_valid,
    output logic [NUM_CH*LDQ_DATA_WIDTH-1:0]            data,
    input  logic [NUM_CH-1:0]                           data_ready,
    output logic                                        ddr_addr_valid,
    input  logic                                        ddr_addr_ready,
    output logic [ADDR_WIDTH-1:0]                       ddr_addr,
    input  logic                                        ddr_data_valid,
    input  logic [DDR_DATA_WIDTH-1:0]                   ddr_data,
    output logic                                        busy,
    output logic                                        err_unexpected
);
    localparam int IDW   = w_of(IDS_NUM);
    localparam int TAGW  = w_of(NUM_CH);
    localparam int BEATS = DDR_DATA_WIDTH / LDQ_DATA_WIDTH;
    localparam int BW    = w_of(BEATS);
    localparam int DEPTH = 2 ** QPTR_WIDTH;
    localparam int SLOTS = NUM_CH * IDS_NUM;
    localparam int SW    = w_of(SLOTS);

    // head: oldest allocated slot; fill: next slot to receive DDR data; tail: next slot to allocate.
    // head <= fill <= tail, each with one extra wrap bit.
    logic [QPTR_WIDTH:0]       head, fill, tail, alloc_cnt, pending_cnt;
    logic [BW-1:0]             beat_idx;
    logic [TAGW-1:0]           tag_mem [DEPTH];
    logic [DDR_DATA_WIDTH-1:0] line_mem [DEPTH];
    logic [OFFSET_WIDTH-1:0]   offset [SLOTS];
    logic [TAGW-1:0]           grant_idx, head_tag;
    logic                      any_grant, can_grant, head_filled, beat_go, pop, fill_en;
    logic [IDW-1:0]            sel_id;
    logic [SW-1:0]             sel;
    logic [ADDR_WIDTH-1:0]     line;
    logic [LDQ_DATA_WIDTH-1:0] beat;

    assign alloc_cnt   = tail - head;
    assign pending_cnt = tail - fill;
    assign head_filled = head != fill;
    assign head_tag    = tag_mem[head[QPTR_WIDTH-1:0]];
    assign beat        = line_mem[head[QPTR_WIDTH-1:0]][beat_idx*LDQ_DATA_WIDTH +: LDQ_DATA_WIDTH];
    assign beat_go     = head_filled && data_ready[head_tag];
    assign pop         = beat_go && beat_idx == BW'(BEATS - 1);
    // Full is the wrap bit of alloc_cnt; a pop in the same cycle frees a slot for pop-through.
    assign can_grant   = !sys_rst && (!alloc_cnt[QPTR_WIDTH] || pop) && (!ddr_addr_valid || ddr_addr_ready);
    assign fill_en     = ddr_data_valid && pending_cnt != '0;
    assign sel_id      = req_id[grant_idx*IDW +: IDW];
    assign sel         = SW'(int'(grant_idx) * IDS_NUM + int'(sel_id));
    assign line        = ADDR_WIDTH'(line_addr(64'(addr_base[sel*BASE_ADDR_WIDTH +: BASE_ADDR_WIDTH]),
                                               64'(offset[sel]), LINE_SHIFT));
    assign busy        = alloc_cnt != '0 || ddr_addr_valid;

    ldq_rr_arbiter #(.N(NUM_CH), .W(TAGW)) u_arb (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .req       (req_valid & {NUM_CH{can_grant}}),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .any       (any_grant)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            head           <= '0;
            fill           <= '0;
            tail           <= '0;
            beat_idx       <= '0;
            ddr_addr_valid <= 1'b0;
            ddr_addr       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (any_grant) begin
                tail     <= tail + 1'b1;
                ddr_addr <= line;
            end
            ddr_addr_valid <= any_grant || (ddr_addr_valid && !ddr_addr_ready);
            if (fill_en) fill <= fill + 1'b1;
            if (ddr_data_valid && !fill_en) err_unexpected <= 1'b1;
            if (beat_go) beat_idx <= pop ? '0 : beat_idx + 1'b1;
            if (pop) head <= head + 1'b1;
        end
    end

    // A clear wins over the increment, so the counter just used also ends at 0.
    always_ff @(posedge sys_clk) begin
        for (int k = 0; k < SLOTS; k++)
            if (sys_rst || offset_clr) offset[k] <= '0;
            else if (any_grant && sel == SW'(k)) offset[k] <= offset[k] + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (any_grant) tag_mem[tail[QPTR_WIDTH-1:0]] <= grant_idx;
        if (fill_en) line_mem[fill[QPTR_WIDTH-1:0]] <= ddr_data;
    end

    always_comb begin
        data_valid = '0;
        data       = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (head_filled && head_tag == TAGW'(c)) begin
                data_valid[c]                                  = 1'b1;
                data[c*LDQ_DATA_WIDTH +: LDQ_DATA_WIDTH]       = beat;
            end
    end
endmodule

// File: tb/tb_sync_multi_ldq.sv
// tb_sync_multi_ldq: directed table-driven bench for sync_multi_ldq with hand-written corner sequences
module tb_sync_multi_ldq;
    import sync_ldq_pkg::*;

    localparam int NC = 4;
    localparam int NI = 8;
    localparam int LW = 128;
    localparam int DW = 512;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic [NC-1:0]     req_valid, req_ready, data_valid, data_ready;
    logic [NC*ID_WIDTH-1:0] req_id;
    logic [NC*NI*20-1:0] addr_base;
    logic              offset_clr;
    logic [NC*LW-1:0]  data;
    logic              ddr_addr_valid, ddr_addr_ready, ddr_data_valid, busy, err_unexpected;
    logic [31:0]       ddr_addr;
    logic [DW-1:0]     ddr_data;
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    sync_multi_ldq dut (
        .sys_clk        (clk),
        .sys_rst        (sys_rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_id         (req_id),
        .addr_base      (addr_base),
        .offset_clr     (offset_clr),
        .data_valid     (data_valid),
        .data           (data),
        .data_ready     (data_ready),
        .ddr_addr_valid (ddr_addr_valid),
        .ddr_addr_ready (ddr_addr_ready),
        .ddr_addr       (ddr_addr),
        .ddr_data_valid (ddr_data_valid),
        .ddr_data       (ddr_data),
        .busy           (busy),
        .err_unexpected (err_unexpected)
    );

    typedef struct {
        int          ch;
        int          id;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_line(input int k);
        logic [DW-1:0] l;
        l = '0;
        for (int b = 0; b < RATIO; b++)
            l[b*LW +: LW] = {32'(k), 32'hA5A5_0000, 32'(b), 32'hC0DE_0000 | 32'(k * 16 + b)};
        return l;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        sys_rst        = 1'b1;
        req_valid      = '0;
        offset_clr     = 1'b0;
        ddr_data_valid = 1'b0;
        data_ready     = '1;
        ddr_addr_ready = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic do_req(input int ch, input int id, input logic clr, input logic [31:0] exp, input string nm);
        @(negedge clk);
        req_valid = '0;
        req_valid[ch] = 1'b1;
        req_id[ch*ID_WIDTH +: ID_WIDTH] = ID_WIDTH'(id);
        offset_clr = clr;
        #1 check({nm, " ready"}, 512'(req_ready), 512'(4'b1 << ch));
        @(negedge clk);
        req_valid  = '0;
        offset_clr = 1'b0;
        check({nm, " avalid"}, 512'(ddr_addr_valid), 512'(1));
        check({nm, " addr"}, 512'(ddr_addr), 512'(exp));
    endtask

    task automatic ret_line(input logic [DW-1:0] l);
        @(negedge clk);
        ddr_data       = l;
        ddr_data_valid = 1'b1;
        @(negedge clk);
        ddr_data_valid = 1'b0;
    endtask

    task automatic drain(input int ch, input logic [DW-1:0] l, input string nm);
        for (int b = 0; b < RATIO; b++) begin
            check({nm, " valid"}, 512'(data_valid), 512'(4'b1 << ch));
            check({nm, " beat"}, 512'(data[ch*LW +: LW]), 512'(l[b*LW +: LW]));
            @(negedge clk);
        end
        check({nm, " done"}, 512'(data_valid), 512'(0));
    endtask

    initial begin
        int cnt;
        int grant_at;
        vt[0] = '{0, 0, 32'h0000_4000};
        vt[1] = '{0, 0, 32'h0000_4040};
        vt[2] = '{0, 0, 32'h0000_4080};
        vt[3] = '{2, 5, 32'h0008_5400};
        vt[4] = '{2, 5, 32'h0008_5440};
        vt[5] = '{3, 7, 32'h000C_5C00};
        vt[6] = '{0, 1, 32'h0000_4400};
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < NI; i++)
                addr_base[(c*NI+i)*20 +: 20] = 20'(32'h100 + c * 32'h1000 + i * 32'h10);
        sys_rst = 1'b0; req_id = '0; ddr_data = '0; req_valid = '0; offset_clr = 1'b0;
        ddr_data_valid = 1'b0; data_ready = '1; ddr_addr_ready = 1'b1;

        do_reset();
        check("rst req_ready", 512'(req_ready), 512'(0));
        check("rst data_valid", 512'(data_valid), 512'(0));
        check("rst ddr_addr_valid", 512'(ddr_addr_valid), 512'(0));
        check("rst data", 512'(data), 512'(0));
        check("rst ddr_addr", 512'(ddr_addr), 512'(0));
        check("rst busy", 512'(busy), 512'(0));
        check("rst err", 512'(err_unexpected), 512'(0));

        do_req(0, 0, 1'b0, 32'h4000, "single");
        ret_line(mk_line(1));
        drain(0, mk_line(1), "single out");
        check("single idle busy", 512'(busy), 512'(0));

        do_reset();
        for (int i = 0; i < 7; i++)
            do_req(vt[i].ch, vt[i].id, 1'b0, vt[i].exp, $sformatf("vec%0d", i));
        do_req(0, 0, 1'b1, 32'h40C0, "clr same cycle");
        do_req(0, 0, 1'b0, 32'h4000, "after clr ch0");
        do_req(2, 5, 1'b0, 32'h85400, "after clr ch2");

        do_reset();
        @(negedge clk);
        req_valid = '1;
        req_id    = '0;
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("rr grant%0d", k), 512'(req_ready), 512'(4'b1 << (k % 4)));
            @(negedge clk);
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            ret_line(mk_line(10 + k));
            drain(k % 4, mk_line(10 + k), $sformatf("rr out%0d", k));
        end

        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        req_id    = '0;
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            #1 if (req_ready[0]) cnt++;
            @(negedge clk);
        end
        check("full grants", 512'(cnt), 512'(16));
        check("full ready", 512'(req_ready), 512'(0));
        ret_line(mk_line(99));
        cnt = 0;
        grant_at = -1;
        for (int i = 0; i < 8; i++) begin
            #1 if (req_ready[0]) begin
                if (grant_at < 0) grant_at = i;
                cnt++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        check("refill grants", 512'(cnt), 512'(1));
        check("pop-through cycle", 512'(grant_at), 512'(RATIO - 1));
        check("full busy", 512'(busy), 512'(1));

        do_reset();
        @(negedge clk);
        ddr_data       = mk_line(5);
        ddr_data_valid = 1'b1;
        @(negedge clk);
        ddr_data_valid = 1'b0;
        check("orphan err", 512'(err_unexpected), 512'(1));
        check("orphan data_valid", 512'(data_valid), 512'(0));
        check("orphan busy", 512'(busy), 512'(0));
        @(negedge clk);
        check("orphan err sticky", 512'(err_unexpected), 512'(1));
        do_reset();
        check("err cleared", 512'(err_unexpected), 512'(0));

        do_reset();
        data_ready = 4'b1101;
        do_req(1, 0, 1'b0, 32'h44000, "hol ch1");
        do_req(2, 0, 1'b0, 32'h84000, "hol ch2");
        ret_line(mk_line(21));
        ret_line(mk_line(22));
        for (int i = 0; i < 3; i++) begin
            check("hol blocked valid", 512'(data_valid), 512'(4'b0010));
            check("hol ch1 beat0", 512'(data[1*LW +: LW]), 512'(mk_line(21) & 512'({LW{1'b1}})));
            check("hol ch2 data", 512'(data[2*LW +: LW]), 512'(0));
            @(negedge clk);
        end
        data_ready = '1;
        for (int b = 0; b < RATIO; b++) begin
            check($sformatf("hol ch1 beat%0d", b), 512'(data[1*LW +: LW]), 512'(mk_line(21) >> (b * LW)) & 512'({LW{1'b1}}));
            @(negedge clk);
        end
        check("hol ch2 valid", 512'(data_valid), 512'(4'b0100));
        check("hol ch2 beat0", 512'(data[2*LW +: LW]), 512'(mk_line(22)) & 512'({LW{1'b1}}));
        @(negedge clk);
        check("hol ch2 beat1", 512'(data[2*LW +: LW]), (512'(mk_line(22)) >> LW) & 512'({LW{1'b1}}));
        sys_rst = 1'b1;
        @(negedge clk);
        check("midrst req_ready", 512'(req_ready), 512'(0));
        check("midrst data_valid", 512'(data_valid), 512'(0));
        check("midrst ddr_addr_valid", 512'(ddr_addr_valid), 512'(0));
        check("midrst data", 512'(data), 512'(0));
        check("midrst ddr_addr", 512'(ddr_addr), 512'(0));
        check("midrst busy", 512'(busy), 512'(0));
        check("midrst err", 512'(err_unexpected), 512'(0));
        sys_rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
